// File: rtl/mem_stage_if.sv
// Bus between the execute stage and the memory stage: the instruction
// presented by execute plus the MEM/WB slot handed on to write-back.
interface mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              en;
  logic              flush;
  logic              in_valid;
  logic [2:0]        mem_op;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [2:0]        rd_in;
  logic              reg_write_in;

  logic              out_valid;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wb_rd;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] sp_out;
  logic              stack_fault;

  modport master (
    output en, flush, in_valid, mem_op, alu_result, store_data, rd_in, reg_write_in,
    input  out_valid, wb_data, wb_rd, wb_reg_write, sp_out, stack_fault
  );

  modport slave (
    input  en, flush, in_valid, mem_op, alu_result, store_data, rd_in, reg_write_in,
    output out_valid, wb_data, wb_rd, wb_reg_write, sp_out, stack_fault
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipelined core: LOAD/STORE/PUSH/POP against a
// single-port synchronous data memory, owner of the stack pointer, and
// holder of the MEM/WB pipeline register.
module mem_stage #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int SP_RESET = (1 << ADDR_W) - 1
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } mem_op_e;

  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_RESET);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_rdata;

  mem_op_e           op;
  logic              accept;
  logic              push_fault;
  logic              pop_fault;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;

  logic              out_valid_q,    out_valid_d;
  logic [DATA_W-1:0] wb_data_q,      wb_data_d;
  logic [2:0]        wb_rd_q,        wb_rd_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              stack_fault_q,  stack_fault_d;
  logic              sel_mem_q,      sel_mem_d;
  logic [ADDR_W-1:0] sp_q,           sp_d;

  // Decode the op code; the unused encodings 5..7 behave as NONE.
  always_comb begin
    op = OP_NONE;
    case (bus.mem_op)
      3'd1:    op = OP_LOAD;
      3'd2:    op = OP_STORE;
      3'd3:    op = OP_PUSH;
      3'd4:    op = OP_POP;
      default: op = OP_NONE;
    endcase
  end

  // Work out the single memory access of this cycle; faults and reset suppress it.
  always_comb begin
    accept     = bus.en && !bus.flush && bus.in_valid;
    push_fault = (op == OP_PUSH) && (sp_q == '0);
    pop_fault  = (op == OP_POP) && (sp_q == SP_TOP);
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = bus.alu_result[ADDR_W-1:0];
    if (accept && !rst) begin
      case (op)
        OP_LOAD:  mem_re = 1'b1;
        OP_STORE: mem_we = 1'b1;
        OP_PUSH: begin
          mem_we   = !push_fault;
          mem_addr = sp_q;
        end
        OP_POP: begin
          mem_re   = !pop_fault;
          mem_addr = sp_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Single-port RAM with a registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= bus.store_data;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Next MEM/WB slot and stack pointer; a stall leaves everything untouched.
  always_comb begin
    out_valid_d    = out_valid_q;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    stack_fault_d  = stack_fault_q;
    sel_mem_d      = sel_mem_q;
    sp_d           = sp_q;
    if (bus.en) begin
      out_valid_d    = accept;
      wb_reg_write_d = 1'b0;
      stack_fault_d  = 1'b0;
      if (accept) begin
        wb_rd_d        = bus.rd_in;
        wb_data_d      = bus.alu_result;
        sel_mem_d      = 1'b0;
        wb_reg_write_d = bus.reg_write_in;
        case (op)
          OP_LOAD:  sel_mem_d = 1'b1;
          OP_STORE: wb_reg_write_d = 1'b0;
          OP_PUSH: begin
            wb_reg_write_d = 1'b0;
            if (push_fault) stack_fault_d = 1'b1;
            else            sp_d = sp_q - ADDR_W'(1);
          end
          OP_POP: begin
            if (pop_fault) begin
              stack_fault_d  = 1'b1;
              wb_reg_write_d = 1'b0;
            end else begin
              sp_d      = sp_q + ADDR_W'(1);
              sel_mem_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // MEM/WB register and stack pointer with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      stack_fault_q  <= 1'b0;
      sel_mem_q      <= 1'b0;
      sp_q           <= SP_TOP;
    end else begin
      out_valid_q    <= out_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      stack_fault_q  <= stack_fault_d;
      sel_mem_q      <= sel_mem_d;
      sp_q           <= sp_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.wb_data      = sel_mem_q ? mem_rdata : wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.sp_out       = sp_q;
  assign bus.stack_fault  = stack_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each driven cycle pushes the expected
// MEM/WB slot computed by a word-array/stack model; a monitor pops and
// compares one slot after every clock edge.
module tb_mem_stage;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [2:0]  rd;
    logic        regw;
    logic        fault;
    logic [9:0]  sp;
    logic        chk_data;
    logic        chk_rd;
  } exp_t;

  logic clk;
  logic rst;
  mem_stage_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  mem_stage #(.DATA_W(16), .ADDR_W(10), .SP_RESET(1023)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks;
  int          n_fails;

  logic [15:0] m_mem [1024];
  int          m_sp;
  exp_t        m_out;

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("out_valid", 32'(bus.out_valid), 32'(e.valid));
    checkField("wb_reg_write", 32'(bus.wb_reg_write), 32'(e.regw));
    checkField("stack_fault", 32'(bus.stack_fault), 32'(e.fault));
    checkField("sp_out", 32'(bus.sp_out), 32'(e.sp));
    if (e.chk_data) checkField("wb_data", 32'(bus.wb_data), 32'(e.data));
    if (e.chk_rd)   checkField("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
  endtask

  // Monitor: one expected slot per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  // Drive one cycle of inputs and push the slot the model predicts for the next edge.
  task automatic applyStimulus(input logic r, input logic e, input logic f, input logic v,
                               input logic [2:0] op, input logic [15:0] alu,
                               input logic [15:0] sd, input logic [2:0] rd, input logic rw);
    int a;
    @(negedge clk);
    rst              = r;
    bus.en           = e;
    bus.flush        = f;
    bus.in_valid     = v;
    bus.mem_op       = op;
    bus.alu_result   = alu;
    bus.store_data   = sd;
    bus.rd_in        = rd;
    bus.reg_write_in = rw;
    a = int'(alu) % 1024;
    if (r) begin
      m_out = '{valid: 1'b0, data: 16'h0, rd: 3'd0, regw: 1'b0, fault: 1'b0,
                sp: 10'd0, chk_data: 1'b1, chk_rd: 1'b1};
      m_sp = 1023;
    end else if (!e) begin
      // stalled: everything holds
    end else if (f || !v) begin
      m_out.valid    = 1'b0;
      m_out.regw     = 1'b0;
      m_out.fault    = 1'b0;
      m_out.chk_data = 1'b0;
      m_out.chk_rd   = 1'b0;
    end else begin
      m_out.valid    = 1'b1;
      m_out.rd       = rd;
      m_out.chk_rd   = 1'b1;
      m_out.regw     = rw;
      m_out.fault    = 1'b0;
      m_out.chk_data = 1'b1;
      m_out.data     = alu;
      case (op)
        3'd1: m_out.data = m_mem[a];
        3'd2: begin
          m_mem[a]       = sd;
          m_out.regw     = 1'b0;
          m_out.chk_data = 1'b0;
        end
        3'd3: begin
          m_out.regw     = 1'b0;
          m_out.chk_data = 1'b0;
          if (m_sp == 0) m_out.fault = 1'b1;
          else begin
            m_mem[m_sp] = sd;
            m_sp        = m_sp - 1;
          end
        end
        3'd4: begin
          if (m_sp == 1023) begin
            m_out.fault    = 1'b1;
            m_out.regw     = 1'b0;
            m_out.chk_data = 1'b0;
          end else begin
            m_sp       = m_sp + 1;
            m_out.data = m_mem[m_sp];
          end
        end
        default: ;
      endcase
    end
    m_out.sp = 10'(m_sp);
    exp_q.push_back(m_out);
  endtask

  task automatic doOp(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] sd,
                      input logic [2:0] rd, input logic rw);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, op, alu, sd, rd, rw);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
  endtask

  // Directed boundary scenarios followed by a randomized phase.
  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_sp     = 1023;
    m_out    = '{valid: 1'b0, data: 16'h0, rd: 3'd0, regw: 1'b0, fault: 1'b0,
                 sp: 10'd1023, chk_data: 1'b0, chk_rd: 1'b0};
    rst              = 1'b1;
    bus.en           = 1'b0;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.mem_op       = 3'd0;
    bus.alu_result   = 16'h0;
    bus.store_data   = 16'h0;
    bus.rd_in        = 3'd0;
    bus.reg_write_in = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
    idle();
    idle();

    // Give every word a known value; upper address bits are noise.
    for (int i = 0; i < 1024; i++)
      doOp(3'd2, {6'($urandom), 10'(i)}, 16'($urandom), 3'($urandom), 1'b1);

    // Store then immediate load through an aliased address.
    doOp(3'd2, 16'h0005, 16'hBEEF, 3'd0, 1'b1);
    doOp(3'd1, 16'h0405, 16'h0000, 3'd3, 1'b1);
    doOp(3'd0, 16'h1234, 16'h0000, 3'd5, 1'b1);

    // Stack push/pop ordering.
    doOp(3'd3, 16'h0, 16'h1111, 3'd0, 1'b1);
    doOp(3'd3, 16'h0, 16'h2222, 3'd0, 1'b1);
    doOp(3'd4, 16'h0, 16'h0, 3'd1, 1'b1);
    doOp(3'd4, 16'h0, 16'h0, 3'd2, 1'b1);

    // Underflow at the empty stack.
    doOp(3'd4, 16'h0, 16'h0, 3'd4, 1'b1);
    idle();

    // Fill to SP=0, then overflow, then confirm mem[0] untouched.
    for (int i = 0; i < 1023; i++)
      doOp(3'd3, 16'h0, 16'($urandom), 3'd0, 1'b0);
    doOp(3'd3, 16'h0, 16'hDEAD, 3'd6, 1'b1);
    doOp(3'd1, 16'h0000, 16'h0, 3'd7, 1'b1);

    // Stall with a store presented: outputs frozen at the load data.
    doOp(3'd1, 16'h0005, 16'h0, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0005, 16'hCAFE, 3'd1, 1'b1);
    // Flushed store must not write.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0005, 16'hCAFE, 3'd1, 1'b1);
    doOp(3'd1, 16'h0005, 16'h0, 3'd3, 1'b1);

    // Push during reset is dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0, 16'hF00D, 3'd5, 1'b1);
    doOp(3'd1, 16'h03FF, 16'h0, 3'd5, 1'b1);
    doOp(3'd4, 16'h0, 16'h0, 3'd1, 1'b1);

    // Randomized mix of all controls and ops.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 4) != 0),
                    3'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) checkField("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
